// File: rtl/spi_disp_pkg.sv
// spi_disp_pkg: command codes, pixel format and receiver state type for the display SPI responder
package spi_disp_pkg;
  localparam logic [7:0] CMD_NOP = 8'h00;
  localparam logic [7:0] CMD_MADCTL = 8'h36;
  localparam logic [7:0] CMD_COLMOD = 8'h3A;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;
  localparam logic [7:0] COLMOD_RGB565 = 8'h55;
  localparam int FRAME_PIXELS = 76800;
  typedef enum logic [1:0] {CMD_WAIT, MADCTL_ARG, COLMOD_ARG, RAMWR_STREAM} RX_STATE_T;
endpackage

// File: rtl/spi_display_receiver_deser.sv
// spi_rx_deserializer: synchronizes the SPI pins, detects SCK rises and assembles MSB-first bytes
module spi_rx_deserializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_cs,
  input  logic       spi_reset,
  input  logic       spi_dc,
  input  logic       spi_sdi,
  input  logic       spi_sck,
  output logic [7:0] BYTE,
  output logic       BYTE_DC,
  output logic       BYTE_VALID,
  output logic       cs_high,
  output logic       soft_rst
);
  logic [4:0] s1_q, s2_q;
  logic       sck_prev_q, rise, clr;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sr_q, sr_d, byte_q, byte_d;
  logic       dc_q, dc_d, full_q, full_d, valid_q, bdc_q, bdc_d;
  assign cs_high = s2_q[4];
  assign soft_rst = ~s2_q[3];
  assign clr = rst | soft_rst;
  assign rise = s2_q[0] & ~sck_prev_q & ~cs_high;
  assign BYTE = byte_q;
  assign BYTE_DC = bdc_q;
  assign BYTE_VALID = valid_q;
  always_comb begin
    sr_d = rise ? {sr_q[6:0], s2_q[1]} : sr_q;
    dc_d = rise ? s2_q[2] : dc_q;
    cnt_d = cs_high ? 3'd0 : cnt_q + {2'd0, rise};
    full_d = rise && cnt_q == 3'd7;
    byte_d = full_q ? sr_q : byte_q;
    bdc_d = full_q ? dc_q : bdc_q;
  end
  // synchronizer chains idle with CS and display reset deasserted
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 5'b11000;
      s2_q <= 5'b11000;
      sck_prev_q <= 1'b0;
    end else begin
      s1_q <= {spi_cs, spi_reset, spi_dc, spi_sdi, spi_sck};
      s2_q <= s1_q;
      sck_prev_q <= s2_q[0];
    end
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= 3'd0;
      sr_q <= 8'd0;
      dc_q <= 1'b0;
      full_q <= 1'b0;
      valid_q <= 1'b0;
      byte_q <= 8'd0;
      bdc_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      dc_q <= dc_d;
      full_q <= full_d;
      valid_q <= full_q;
      byte_q <= byte_d;
      bdc_q <= bdc_d;
    end
  end
endmodule

// File: rtl/spi_display_receiver.sv
// spi_display_receiver: decodes display SPI commands and downsamples the RAMWR pixel stream into framebuffer writes
module spi_display_receiver
  import spi_disp_pkg::*;
#(
  parameter int H_RES = 320,
  parameter int V_RES = 240,
  parameter int FB_W = 160
) (
  input  logic        CLK_50MHz,
  input  logic        RESET,
  input  logic        SPI_CS,
  input  logic        SPI_RESET,
  input  logic        SPI_DC,
  input  logic        SPI_SDI,
  input  logic        SPI_SCK,
  output logic [14:0] WA,
  output logic [15:0] WD,
  output logic        WE,
  output logic [7:0]  MADCTL,
  output logic [7:0]  COLMOD,
  output logic        FRAME_DONE,
  output logic        FMT_ERR
);
  logic [7:0]  rx_byte;
  logic        rx_dc, rx_valid, cs_high, soft_rst, rst_all;
  RX_STATE_T   state_q, state_d;
  logic        hi_pend_q, hi_pend_d, we_q, we_d, fd_q, fd_d, fmt_err_q, fmt_err_d;
  logic [7:0]  hi_q, hi_d, madctl_q, madctl_d, colmod_q, colmod_d;
  logic [8:0]  col_q, col_d;
  logic [7:0]  row_q, row_d;
  logic [14:0] base_q, base_d, wa_q, wa_d;
  logic [15:0] wd_q, wd_d;
  logic        fmt_ok, wr, last_col, last_row;
  spi_rx_deserializer u_deser (
    .clk(CLK_50MHz), .rst(RESET), .spi_cs(SPI_CS), .spi_reset(SPI_RESET), .spi_dc(SPI_DC),
    .spi_sdi(SPI_SDI), .spi_sck(SPI_SCK), .BYTE(rx_byte), .BYTE_DC(rx_dc), .BYTE_VALID(rx_valid),
    .cs_high(cs_high), .soft_rst(soft_rst)
  );
  assign rst_all = RESET | soft_rst;
  assign fmt_ok = colmod_q == COLMOD_RGB565;
  assign wr = fmt_ok & ~col_q[0] & ~row_q[0];
  assign last_col = col_q == 9'(H_RES - 1);
  assign last_row = row_q == 8'(V_RES - 1);
  assign {WA, WD, WE, MADCTL, COLMOD, FRAME_DONE, FMT_ERR} =
         {wa_q, wd_q, we_q, madctl_q, colmod_q, fd_q, fmt_err_q};
  always_comb begin
    state_d = state_q;
    hi_pend_d = hi_pend_q & ~cs_high;
    hi_d = hi_q;
    col_d = col_q;
    row_d = row_q;
    base_d = base_q;
    wa_d = wa_q;
    wd_d = wd_q;
    we_d = 1'b0;
    madctl_d = madctl_q;
    colmod_d = colmod_q;
    fd_d = 1'b0;
    fmt_err_d = fmt_err_q;
    if (rx_valid && !rx_dc) begin
      hi_pend_d = 1'b0;
      state_d = rx_byte == CMD_MADCTL ? MADCTL_ARG :
                rx_byte == CMD_COLMOD ? COLMOD_ARG :
                rx_byte == CMD_RAMWR  ? RAMWR_STREAM : CMD_WAIT;
      if (rx_byte == CMD_RAMWR) begin
        col_d = 9'd0;
        row_d = 8'd0;
        base_d = 15'd0;
      end
    end else if (rx_valid) begin
      if (state_q == MADCTL_ARG) begin
        madctl_d = rx_byte;
        state_d = CMD_WAIT;
      end
      if (state_q == COLMOD_ARG) begin
        colmod_d = rx_byte;
        state_d = CMD_WAIT;
      end
      if (state_q == RAMWR_STREAM && !hi_pend_q) begin
        hi_d = rx_byte;
        hi_pend_d = 1'b1;
      end
      if (state_q == RAMWR_STREAM && hi_pend_q) begin
        hi_pend_d = 1'b0;
        fmt_err_d = fmt_err_q | ~fmt_ok;
        we_d = wr;
        wd_d = wr ? {hi_q, rx_byte} : wd_q;
        wa_d = wr ? base_q + {7'd0, col_q[8:1]} : wa_q;
        col_d = last_col ? 9'd0 : col_q + 9'd1;
        row_d = !last_col ? row_q : last_row ? 8'd0 : row_q + 8'd1;
        // line base steps once per pair of source rows
        base_d = !last_col ? base_q : last_row ? 15'd0 : row_q[0] ? base_q + 15'(FB_W) : base_q;
        fd_d = last_col & last_row;
      end
    end
  end
  always_ff @(posedge CLK_50MHz) begin
    if (rst_all) begin
      state_q <= CMD_WAIT;
      hi_pend_q <= 1'b0;
      hi_q <= 8'd0;
      col_q <= 9'd0;
      row_q <= 8'd0;
      base_q <= 15'd0;
      wa_q <= 15'd0;
      wd_q <= 16'd0;
      we_q <= 1'b0;
      madctl_q <= 8'h00;
      colmod_q <= 8'h66;
      fd_q <= 1'b0;
      fmt_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_pend_q <= hi_pend_d;
      hi_q <= hi_d;
      col_q <= col_d;
      row_q <= row_d;
      base_q <= base_d;
      wa_q <= wa_d;
      wd_q <= wd_d;
      we_q <= we_d;
      madctl_q <= madctl_d;
      colmod_q <= colmod_d;
      fd_q <= fd_d;
      fmt_err_q <= fmt_err_d;
    end
  end
endmodule

// File: tb/tb_spi_display_receiver.sv
// tb_spi_display_receiver: directed vector bench for the display SPI responder on a reduced 8x6 geometry
module tb_spi_display_receiver;
  localparam int HR = 8, VR = 6, FW = 4;
  logic clk = 0, RESET = 1, SPI_CS = 1, SPI_RESET = 1, SPI_DC = 0, SPI_SDI = 0, SPI_SCK = 0;
  logic [14:0] WA;
  logic [15:0] WD;
  logic        WE, FRAME_DONE, FMT_ERR;
  logic [7:0]  MADCTL, COLMOD;
  int cyc = 0, checks = 0, errors = 0, last_k = 0, we_cnt = 0, fd_cnt = 0, fd_cyc = 0, rd = 0;
  logic [14:0] obs_wa[256];
  logic [15:0] obs_wd[256];
  int obs_cyc[256];

  typedef struct {logic dc; logic [7:0] v; logic [7:0] madctl; logic [7:0] colmod; int wes;} vec_t;
  vec_t tbl[13];

  spi_display_receiver #(.H_RES(HR), .V_RES(VR), .FB_W(FW)) dut (
    .CLK_50MHz(clk), .RESET(RESET), .SPI_CS(SPI_CS), .SPI_RESET(SPI_RESET), .SPI_DC(SPI_DC),
    .SPI_SDI(SPI_SDI), .SPI_SCK(SPI_SCK), .WA(WA), .WD(WD), .WE(WE), .MADCTL(MADCTL),
    .COLMOD(COLMOD), .FRAME_DONE(FRAME_DONE), .FMT_ERR(FMT_ERR)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (WE && we_cnt < 256) begin
      obs_wa[we_cnt] = WA;
      obs_wd[we_cnt] = WD;
      obs_cyc[we_cnt] = cyc;
      we_cnt++;
    end
    if (FRAME_DONE) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bits(input logic dc, input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk); SPI_DC = dc; SPI_SDI = v[i]; SPI_SCK = 0;
      @(negedge clk);
      @(negedge clk); SPI_SCK = 1; last_k = cyc + 1;
      @(negedge clk);
    end
    @(negedge clk); SPI_SCK = 0;
    repeat (6) @(negedge clk);
  endtask

  task automatic tx(input logic dc, input logic [7:0] v);
    send_bits(dc, v, 8);
  endtask

  task automatic pixel(input logic [15:0] p);
    tx(1, p[15:8]);
    tx(1, p[7:0]);
  endtask

  task automatic expect_we(input logic [14:0] wa, input logic [15:0] wd);
    chk("we_present", (we_cnt > rd) ? 1 : 0, 1);
    if (we_cnt > rd) begin
      chk("wa", 32'(obs_wa[rd]), 32'(wa));
      chk("wd", 32'(obs_wd[rd]), 32'(wd));
      rd++;
    end
  endtask

  task automatic expect_none();
    chk("no_extra_we", we_cnt - rd, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wa", 32'(WA), 0);
    chk("rst_wd", 32'(WD), 0);
    chk("rst_we", 32'(WE), 0);
    chk("rst_madctl", 32'(MADCTL), 32'h00);
    chk("rst_colmod", 32'(COLMOD), 32'h66);
    chk("rst_frame_done", 32'(FRAME_DONE), 0);
    chk("rst_fmt_err", 32'(FMT_ERR), 0);
  endtask

  initial begin
    int k_p0, k_last, fd0, r, c;
    tbl[0]  = '{1'b0, 8'h36, 8'h00, 8'h66, 0};
    tbl[1]  = '{1'b1, 8'h20, 8'h20, 8'h66, 0};
    tbl[2]  = '{1'b0, 8'h3A, 8'h20, 8'h66, 0};
    tbl[3]  = '{1'b1, 8'h55, 8'h20, 8'h55, 0};
    tbl[4]  = '{1'b0, 8'h00, 8'h20, 8'h55, 0};
    tbl[5]  = '{1'b1, 8'h77, 8'h20, 8'h55, 0};
    tbl[6]  = '{1'b0, 8'h2C, 8'h20, 8'h55, 0};
    tbl[7]  = '{1'b1, 8'h12, 8'h20, 8'h55, 0};
    tbl[8]  = '{1'b1, 8'h34, 8'h20, 8'h55, 1};
    tbl[9]  = '{1'b1, 8'hAB, 8'h20, 8'h55, 1};
    tbl[10] = '{1'b1, 8'hCD, 8'h20, 8'h55, 1};
    tbl[11] = '{1'b0, 8'h36, 8'h20, 8'h55, 1};
    tbl[12] = '{1'b1, 8'h08, 8'h08, 8'h55, 1};
    k_p0 = 0;
    repeat (3) @(negedge clk);
    chk_reset_vals();
    RESET = 0;
    @(negedge clk); SPI_CS = 0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      tx(tbl[i].dc, tbl[i].v);
      if (i == 8) k_p0 = last_k;
      chk("tbl_madctl", 32'(MADCTL), 32'(tbl[i].madctl));
      chk("tbl_colmod", 32'(COLMOD), 32'(tbl[i].colmod));
      chk("tbl_we_count", we_cnt, tbl[i].wes);
      chk("tbl_fmt_err", 32'(FMT_ERR), 0);
    end
    if (we_cnt > rd) chk("we_latency", obs_cyc[rd] - k_p0, 4);
    expect_we(15'd0, 16'h1234);
    expect_none();

    fd0 = fd_cnt;
    k_last = 0;
    tx(0, 8'h2C);
    for (int idx = 0; idx < HR * VR + 2; idx++) begin
      r = (idx / HR) % VR;
      c = idx % HR;
      pixel(16'(idx));
      if (idx == HR * VR - 1) k_last = last_k;
      if (r % 2 == 0 && c % 2 == 0) expect_we(15'((r / 2) * FW + c / 2), 16'(idx));
      expect_none();
    end
    chk("frame_done_count", fd_cnt - fd0, 1);
    chk("frame_done_slot", fd_cyc - k_last, 4);
    chk("frame_fmt_err", 32'(FMT_ERR), 0);

    @(negedge clk); RESET = 1;
    @(negedge clk); RESET = 0;
    chk_reset_vals();
    rd = we_cnt;
    tx(0, 8'h2C);
    pixel(16'h0102);
    chk("fmt_err_set", 32'(FMT_ERR), 1);
    expect_none();
    tx(0, 8'h3A);
    tx(1, 8'h55);
    tx(0, 8'h2C);
    pixel(16'h5555);
    expect_we(15'd0, 16'h5555);
    chk("fmt_err_sticky", 32'(FMT_ERR), 1);

    tx(0, 8'h2C);
    send_bits(1, 8'hFF, 5);
    SPI_CS = 1;
    repeat (4) @(negedge clk);
    SPI_CS = 0;
    repeat (4) @(negedge clk);
    pixel(16'h00FF);
    expect_we(15'd0, 16'h00FF);
    expect_none();
    tx(1, 8'h77);
    tx(0, 8'h2C);
    expect_none();
    pixel(16'h4321);
    expect_we(15'd0, 16'h4321);
    expect_none();

    tx(0, 8'h36);
    tx(1, 8'h5A);
    chk("madctl_pre_reset", 32'(MADCTL), 32'h5A);
    send_bits(0, 8'h3A, 3);
    RESET = 1;
    @(negedge clk); RESET = 0;
    chk_reset_vals();
    repeat (2) @(negedge clk);
    tx(0, 8'h36);
    tx(1, 8'hC3);
    chk("madctl_after_reset", 32'(MADCTL), 32'hC3);
    SPI_RESET = 0;
    repeat (4) @(negedge clk);
    chk("spi_reset_madctl", 32'(MADCTL), 32'h00);
    chk("spi_reset_colmod", 32'(COLMOD), 32'h66);
    SPI_RESET = 1;
    repeat (4) @(negedge clk);
    chk("spi_reset_released", 32'(MADCTL), 32'h00);
    tx(0, 8'h3A);
    tx(1, 8'h55);
    chk("colmod_after_spi_reset", 32'(COLMOD), 32'h55);
    expect_none();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_display_receiver.md
Name: spi_display_receiver

Overview:
- Responder end of the display SPI link. It emulates the display-side decoder for on-board loopback and for verification of the framebuffer driver.
- Oversamples CS/RESET/DC/SDI/SCK on CLK_50MHz, deserializes bytes and decodes NOP, MADCTL, COLMOD and RAMWR.
- Converts the 320x240 RAMWR pixel stream into 160x120 framebuffer write-port transactions (WA/WD/WE) by keeping the top-left pixel of each 2x2 block.

Parameters:
- H_RES, 320, incoming pixels per line
- V_RES, 240, incoming lines per frame
- FB_W, 160, framebuffer width (H_RES/2)

Ports:
- CLK_50MHz  input  1  system clock
- RESET  input  1  synchronous, active-high reset
- SPI_CS  input  1  chip select, active low, asynchronous
- SPI_RESET  input  1  display reset, active low, asynchronous
- SPI_DC  input  1  0 = command byte, 1 = data byte
- SPI_SDI  input  1  serial data, MSB first
- SPI_SCK  input  1  serial clock, idle low, max 12.5 MHz
- WA  output  15  framebuffer write address
- WD  output  16  framebuffer write data (RGB565)
- WE  output  1  one-cycle write strobe
- MADCTL  output  8  last MADCTL argument
- COLMOD  output  8  last COLMOD argument
- FRAME_DONE  output  1  one-cycle pulse when incoming pixel 76799 is consumed
- FMT_ERR  output  1  sticky; set when pixel data arrives with COLMOD != 0x55

Behaviour:
- Reset values: RESET=1 is sampled on a CLK edge. WA=0, WD=0, WE=0, MADCTL=0x00, COLMOD=0x66, FRAME_DONE=0, FMT_ERR=0, state=CMD_WAIT, bit count=0, pixel col/row=0, high-byte-pending=0.
- Synchronized SPI_RESET low has the same effect as RESET, held for as long as it stays low.
- Synchronizers: every SPI input passes through 2 flops. An SCK rising edge is detected from the synchronized value against its previous value.
- Sampling: SDI is shifted in on each detected SCK rise while synchronized CS=0.
- Byte completion: after the 8th bit, a byte strobe fires one cycle after the edge detect, carrying the byte and the DC value sampled with bit 0.
- Byte latency: let k be the first CLK edge that captures raw SCK high for a byte's last bit. The byte strobe is at k+3 and the resulting WE is at k+4.
- Synchronized CS high clears the partial bit count and any pending pixel high byte. The FSM state is kept.
- FSM states: CMD_WAIT, MADCTL_ARG, COLMOD_ARG, RAMWR_STREAM.
- A command byte (DC=0) in any state is decoded immediately and aborts any pending high byte:
  - 0x00 -> CMD_WAIT
  - 0x36 -> MADCTL_ARG
  - 0x3A -> COLMOD_ARG
  - 0x2C -> col=row=0, -> RAMWR_STREAM
  - any other value -> CMD_WAIT
- Data bytes (DC=1):
  - CMD_WAIT: ignored.
  - MADCTL_ARG: MADCTL<=byte, -> CMD_WAIT.
  - COLMOD_ARG: COLMOD<=byte, -> CMD_WAIT.
  - RAMWR_STREAM: the first byte is the pixel high byte, the second is the low byte. Pixel = {hi, lo}. State remains RAMWR_STREAM.
- Pixel handling, per completed pixel:
  - If COLMOD != 0x55: set FMT_ERR and issue no WE. Col/row still advance.
  - Otherwise, if col[0]==0 and row[0]==0: WE=1 for one cycle, WD=pixel, WA=(row>>1)*FB_W+(col>>1).
  - WA is generated from an incremental line-base register; no multiplier or divider.
  - WA and WD hold their values between strobes.
- Address advance: col increments; at col==H_RES-1, col<=0 and row increments. At row==V_RES-1 with col==H_RES-1, both wrap to 0 and FRAME_DONE pulses in the same cycle as that pixel's processing slot.
- Streaming continues past the wrap into the next frame without a new RAMWR.
- Max WA = 19199. WA never exceeds this.
- Simultaneous events: RESET dominates everything. A command strobe dominates pixel assembly.

Decomposition:
- Package spi_disp_pkg:
  - command constants CMD_NOP=0x00, CMD_MADCTL=0x36, CMD_COLMOD=0x3A, CMD_RAMWR=0x2C
  - COLMOD_RGB565=0x55
  - enum RX_STATE_T
  - FRAME_PIXELS=76800
- Sub-module spi_rx_deserializer: the synchronizers, SCK edge detect, bit counter and shift register. It outputs BYTE, BYTE_DC and BYTE_VALID.
- The top level holds the command FSM, pixel assembly and address generation.

Test Plan:
1. Send command 0x36 then data 0x20, command 0x3A then data 0x55 (SCK 12.5 MHz) -> MADCTL=0x20, COLMOD=0x55, no WE, FMT_ERR=0.
2. Send RAMWR, then pixels 0x1234 (p0) and 0xABCD (p1) -> exactly one WE, WA=0, WD=0x1234. WE is at k+4 after p0's LSB SCK rise. p1 produces no write.
3. Send a full 76800-pixel frame with pixel value = index[15:0] -> 19200 WEs, each at WA=(r/2)*160+(c/2) with WD equal to the even/even index. The last WE is at WA=19199. FRAME_DONE pulses exactly once, on pixel 76799.
4. After RESET, send RAMWR plus one pixel with no COLMOD -> FMT_ERR=1, WE never asserts. Then send COLMOD 0x55 and RAMWR 0x5555 -> WE at WA=0. FMT_ERR stays 1.
5. Toggle CS high after 5 bits of a pixel high byte, then send a full pixel 0x00FF -> WE with WD=0x00FF. Also send command 0x2C after only the high byte of a pixel -> no WE, and the next pixel writes WA=0.
6. Assert RESET mid-byte, or hold SPI_RESET low for 4 cycles -> all outputs return to their reset values next cycle. The next complete byte decodes correctly.
